// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA timing master. Divides clk down to a one-clk pixel enable
//               (p_tick), runs the horizontal/vertical pixel counters, and
//               produces registered active-low hsync/vsync, a combinational
//               video_on window and a frame_tick pulse at the start of
//               vertical blanking.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1   system clock
//   reset      in   1   asynchronous reset, active low
//   p_tick     out  1   pixel enable, one clk wide every TICK_DIV clks
//   pixel_x    out  10  horizontal count, 0..HT-1
//   pixel_y    out  10  vertical count, 0..VT-1
//   video_on   out  1   high while pixel_x < HD and pixel_y < VD
//   hsync      out  1   horizontal sync, active low, straight from a flop
//   vsync      out  1   vertical sync, active low, straight from a flop
//   frame_tick out  1   one-clk pulse as the counts enter (0, VD)
// Optional macro:
//   FRAME_DIV_EN - when defined, frame_tick fires only on every FRAME_DIV-th
//                  frame event; when undefined it fires on every frame.
// Parameter constraints: HD+HF+HR+HB <= 1024, VD+VF+VR+VB <= 1024,
//                        TICK_DIV >= 1, FRAME_DIV >= 1.
// ============================================================================
module vga_sync_gen #(
  parameter int HD        = 640,
  parameter int HF        = 16,
  parameter int HR        = 96,
  parameter int HB        = 48,
  parameter int VD        = 480,
  parameter int VF        = 10,
  parameter int VR        = 2,
  parameter int VB        = 33,
  parameter int TICK_DIV  = 2,
  parameter int FRAME_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int c_HT = HD + HF + HR + HB;
  localparam int c_VT = VD + VF + VR + VB;

  localparam logic [9:0] c_X_LAST     = 10'(c_HT - 1);
  localparam logic [9:0] c_Y_LAST     = 10'(c_VT - 1);
  localparam logic [9:0] c_X_VIS      = 10'(HD);
  localparam logic [9:0] c_Y_VIS      = 10'(VD);
  localparam logic [9:0] c_Y_VIS_LAST = 10'(VD - 1);
  localparam logic [9:0] c_HS_START   = 10'(HD + HF);
  localparam logic [9:0] c_HS_END     = 10'(HD + HF + HR - 1);
  localparam logic [9:0] c_VS_START   = 10'(VD + VF);
  localparam logic [9:0] c_VS_END     = 10'(VD + VF + VR - 1);

  localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

  // --------------------------------------------------------------------------
  // Pixel-rate enable. p_tick is registered from the divider's terminal count
  // so it is 0 in reset and, with TICK_DIV=1, becomes a constant 1 from the
  // first edge after release.
  // --------------------------------------------------------------------------
  logic [c_TW-1:0] r_tick_cnt;
  logic            r_p_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_p_tick   <= 1'b0;
    end else begin
      if (r_tick_cnt == c_TICK_LAST) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_p_tick <= (r_tick_cnt == c_TICK_LAST);
    end
  end

  // --------------------------------------------------------------------------
  // Next-position logic for the raster counters.
  // --------------------------------------------------------------------------
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_next;
  logic       w_vs_next;

  always_comb begin
    w_x_next = r_x + 10'd1;
    w_y_next = r_y;
    if (r_x == c_X_LAST) begin
      w_x_next = '0;
      if (r_y == c_Y_LAST) begin
        w_y_next = '0;
      end else begin
        w_y_next = r_y + 10'd1;
      end
    end
  end

  // Sync levels are computed from the next position so the registered sync
  // flips on the same edge that moves the counters into/out of the pulse.
  always_comb begin
    w_hs_next = !((w_x_next >= c_HS_START) && (w_x_next <= c_HS_END));
    w_vs_next = !((w_y_next >= c_VS_START) && (w_y_next <= c_VS_END));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (r_p_tick) begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= w_hs_next;
      r_vsync <= w_vs_next;
    end
  end

  // --------------------------------------------------------------------------
  // Frame event: active during the clk in which the counts step from the last
  // visible pixel to (0, VD), i.e. the first cycle of vertical blanking.
  // --------------------------------------------------------------------------
  logic w_frame_raw;

  always_comb begin
    w_frame_raw = r_p_tick && (r_x == c_X_LAST) && (r_y == c_Y_VIS_LAST);
  end

`ifdef FRAME_DIV_EN
  localparam int c_FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAME_DIV - 1);

  logic [c_FW-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_raw) begin
      if (r_frame_cnt == c_FRAME_LAST) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Only the FRAME_DIV-th raw event of each group reaches the output.
  assign frame_tick = w_frame_raw && (r_frame_cnt == c_FRAME_LAST);
`else
  assign frame_tick = w_frame_raw;
`endif

  assign p_tick   = r_p_tick;
  assign pixel_x  = r_x;
  assign pixel_y  = r_y;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = (r_x < c_X_VIS) && (r_y < c_Y_VIS);

endmodule
`default_nettype wire
